// File: rtl/spi_transmit_da2.sv
// spi_transmit_da2: dual-channel serial feeder for a two-DAC module.
// Each frame sends one 16-bit word to each DAC on a shared sclk/ncs.
//
// Parameters
//   HALF_PERIOD : clk cycles per sclk half-period (1..255)
//   PD_MODE     : power-down bits placed in every word
// Ports
//   clk    : system clock
//   rst    : synchronous reset, active low
//   data1  : channel-1 DAC code (12 bits)
//   data2  : channel-2 DAC code (12 bits)
//   start  : request one frame on both channels
//   sclk   : shared SPI clock, idle high
//   ncs    : shared active-low frame sync
//   sdata1 : serial data, channel 1
//   sdata2 : serial data, channel 2
//   done   : one-cycle pulse at frame end
//   busy   : high during frame and trailing gap
module spi_transmit_da2 #(
  parameter int         HALF_PERIOD = 2,
  parameter logic [1:0] PD_MODE     = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] data1,
  input  logic [11:0] data2,
  input  logic        start,
  output logic        sclk,
  output logic        ncs,
  output logic        sdata1,
  output logic        sdata2,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

  state_t      r_state;
  logic [7:0]  r_hcnt;
  logic [3:0]  r_bcnt;
  logic        r_gap;
  logic [15:0] r_sh1;
  logic [15:0] r_sh2;
  logic        r_sclk;
  logic        r_ncs;
  logic        r_sd1;
  logic        r_sd2;
  logic        r_done;
  logic        r_busy;

  logic [15:0] w_word1;
  logic [15:0] w_word2;
  logic        w_half_end;
  logic        w_last_bit;

  assign w_word1    = {2'b00, PD_MODE, data1};
  assign w_word2    = {2'b00, PD_MODE, data2};
  assign w_half_end = (r_hcnt == HP_LAST);
  assign w_last_bit = (r_bcnt == 4'd15);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_hcnt  <= 8'd0;
      r_bcnt  <= 4'd0;
      r_gap   <= 1'b0;
      r_sh1   <= 16'd0;
      r_sh2   <= 16'd0;
      r_sclk  <= 1'b1;
      r_ncs   <= 1'b1;
      r_sd1   <= 1'b0;
      r_sd2   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            // MSB goes out immediately; the rest waits in the shifter
            r_state <= S_SHIFT;
            r_ncs   <= 1'b0;
            r_sclk  <= 1'b1;
            r_sd1   <= w_word1[15];
            r_sd2   <= w_word2[15];
            r_sh1   <= {w_word1[14:0], 1'b0};
            r_sh2   <= {w_word2[14:0], 1'b0};
            r_hcnt  <= 8'd0;
            r_bcnt  <= 4'd0;
            r_busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (!w_half_end) begin
            r_hcnt <= r_hcnt + 8'd1;
          end else begin
            r_hcnt <= 8'd0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
            end else if (w_last_bit) begin
              r_state <= S_GAP;
              r_ncs   <= 1'b1;
              r_sclk  <= 1'b1;
              r_sd1   <= 1'b0;
              r_sd2   <= 1'b0;
              r_sh1   <= 16'd0;
              r_sh2   <= 16'd0;
              r_bcnt  <= 4'd0;
              r_gap   <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              // new bit only on the rising sclk edge
              r_bcnt <= r_bcnt + 4'd1;
              r_sclk <= 1'b1;
              r_sd1  <= r_sh1[15];
              r_sd2  <= r_sh2[15];
              r_sh1  <= {r_sh1[14:0], 1'b0};
              r_sh2  <= {r_sh2[14:0], 1'b0};
            end
          end
        end
        S_GAP: begin
          if (r_gap) begin
            r_state <= S_IDLE;
            r_gap   <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sclk   = r_sclk;
  assign ncs    = r_ncs;
  assign sdata1 = r_sd1;
  assign sdata2 = r_sd2;
  assign done   = r_done;
  assign busy   = r_busy;

endmodule

// File: tb/tb_spi_transmit_da2.sv
// tb_spi_transmit_da2: scoreboard bench for spi_transmit_da2.
// Two instances: defaults, and HALF_PERIOD=1 / PD_MODE=2'b11.
module tb_spi_transmit_da2;

  logic        clk;
  logic        rst;
  logic [11:0] d1 [2];
  logic [11:0] d2 [2];
  logic        st [2];
  logic        sclk_o [2];
  logic        ncs_o [2];
  logic        sd1_o [2];
  logic        sd2_o [2];
  logic        done_o [2];
  logic        busy_o [2];

  int errors = 0;
  int checks = 0;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  logic        mon_en = 1'b0;
  logic        abrt [2];
  logic        held [2];

  spi_transmit_da2 #(.HALF_PERIOD(2), .PD_MODE(2'b00)) u0 (
    .clk(clk), .rst(rst),
    .data1(d1[0]), .data2(d2[0]), .start(st[0]),
    .sclk(sclk_o[0]), .ncs(ncs_o[0]),
    .sdata1(sd1_o[0]), .sdata2(sd2_o[0]),
    .done(done_o[0]), .busy(busy_o[0])
  );

  spi_transmit_da2 #(.HALF_PERIOD(1), .PD_MODE(2'b11)) u1 (
    .clk(clk), .rst(rst),
    .data1(d1[1]), .data2(d2[1]), .start(st[1]),
    .sclk(sclk_o[1]), .ncs(ncs_o[1]),
    .sdata1(sd1_o[1]), .sdata2(sd2_o[1]),
    .done(done_o[1]), .busy(busy_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hp(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [1:0] pd(input int i);
    return (i == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [11:0] a,
                      input logic [11:0] b);
    logic [31:0] e;
    e = {2'b00, pd(i), a, 2'b00, pd(i), b};
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // issue start, check cycle-1 outputs, scramble inputs, pace by model
  task automatic run_frame(input int i, input logic [11:0] a,
                           input logic [11:0] b, input int gap);
    d1[i] = a;
    d2[i] = b;
    st[i] = 1'b1;
    push(i, a, b);
    @(posedge clk); #1;
    st[i] = 1'b0;
    chk("start_lat", {ncs_o[i], sclk_o[i], busy_o[i]}, 3'b011);
    d1[i] = 12'($urandom);
    d2[i] = 12'($urandom);
    repeat (32 * hp(i) + 2 + gap) @(posedge clk);
    #1;
  endtask

  // monitor: rebuilds words from falling sclk edges
  int          lowcnt [2];
  int          falls [2];
  int          hicnt [2];
  int          sr [2];
  logic        pncs [2];
  logic        psclk [2];
  logic [15:0] w1 [2];
  logic [15:0] w2 [2];

  initial begin
    wait (mon_en);
    for (int i = 0; i < 2; i++) begin
      pncs[i]   = ncs_o[i];
      psclk[i]  = sclk_o[i];
      sr[i]     = 9;
      hicnt[i]  = 9;
      lowcnt[i] = 0;
      falls[i]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic        rise;
        logic        fall;
        logic [31:0] e;
        rise = !pncs[i] && ncs_o[i];
        fall = pncs[i] && !ncs_o[i];
        if (fall) begin
          if (held[i]) chk("gap_len", hicnt[i], 3);
          lowcnt[i] = 0;
          falls[i]  = 0;
        end
        if (!ncs_o[i]) begin
          lowcnt[i]++;
          if (psclk[i] && !sclk_o[i]) begin
            w1[i] = {w1[i][14:0], sd1_o[i]};
            w2[i] = {w2[i][14:0], sd2_o[i]};
            falls[i]++;
            chk("busy_shift", busy_o[i], 1);
          end
        end
        if (rise) begin
          hicnt[i] = 1;
          sr[i]    = 0;
          if (abrt[i]) begin
            abrt[i] = 1'b0;
            sr[i]   = 9;
            if (i == 0 && q0.size() > 0) void'(q0.pop_front());
            if (i == 1 && q1.size() > 0) void'(q1.pop_front());
            chk("abort_done", done_o[i], 0);
          end else if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            chk("unexpected_frame", 0, 1);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk("word_ch1", w1[i], e[31:16]);
            chk("word_ch2", w2[i], e[15:0]);
            chk("fall_count", falls[i], 16);
            chk("ncs_low_len", lowcnt[i], 32 * hp(i));
            chk("end_state", {done_o[i], sclk_o[i], sd1_o[i],
                              sd2_o[i], busy_o[i]}, 5'b11001);
          end
        end else begin
          if (ncs_o[i]) begin
            hicnt[i]++;
            if (sr[i] < 9) sr[i]++;
          end
          if (done_o[i]) chk("stray_done", done_o[i], 0);
          if (ncs_o[i] && sr[i] == 1) chk("gap_busy", busy_o[i], 1);
          if (ncs_o[i] && sr[i] == 2) chk("idle_busy", busy_o[i], 0);
        end
        pncs[i]  = ncs_o[i];
        psclk[i] = sclk_o[i];
      end
    end
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d1[i]   = 12'($urandom);
      d2[i]   = 12'($urandom);
      st[i]   = 1'b1;
      abrt[i] = 1'b0;
      held[i] = 1'b0;
    end

    // start must be ignored while in reset
    repeat (5) begin
      @(posedge clk); #1;
      chk("rst_idle0", {ncs_o[0], sclk_o[0], sd1_o[0], sd2_o[0],
                        done_o[0], busy_o[0]}, 6'b110000);
      chk("rst_idle1", {ncs_o[1], sclk_o[1], sd1_o[1], sd2_o[1],
                        done_o[1], busy_o[1]}, 6'b110000);
    end
    st[0]  = 1'b0;
    st[1]  = 1'b0;
    mon_en = 1'b1;
    rst    = 1'b1;
    @(posedge clk); #1;
    chk("no_start_after_rst", ncs_o[0], 1);

    run_frame(0, 12'hA5C, 12'h3F0, 2);
    run_frame(1, 12'h000, 12'hFFF, 2);

    // data change and second start mid-frame are ignored
    d1[0] = 12'h5A1;
    d2[0] = 12'hC3E;
    st[0] = 1'b1;
    push(0, 12'h5A1, 12'hC3E);
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    d1[0] = 12'h0F0;
    d2[0] = 12'hF0F;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("mid_start_q", q0.size(), 0);

    // reset at cycle 30 aborts the frame
    d1[0] = 12'h777;
    d2[0] = 12'h888;
    st[0] = 1'b1;
    push(0, 12'h777, 12'h888);
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    abrt[0] = 1'b1;
    rst     = 1'b0;
    @(posedge clk); #1;
    chk("abort_out", {ncs_o[0], sclk_o[0], done_o[0], busy_o[0]},
        4'b1100);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_seen", abrt[0], 0);
    chk("abort_q", q0.size(), 0);
    run_frame(0, 12'h123, 12'hABC, 1);

    // start held high: three back-to-back frames
    d1[0] = 12'h9E4;
    d2[0] = 12'h17B;
    for (int k = 0; k < 3; k++) push(0, 12'h9E4, 12'h17B);
    st[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    held[0] = 1'b1;
    repeat (132) @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (69) @(posedge clk);
    #1;
    held[0] = 1'b0;
    chk("held_q", q0.size(), 0);

    for (int k = 0; k < 14; k++) begin
      int i;
      i = int'($urandom_range(1, 0));
      run_frame(i, 12'($urandom), 12'($urandom),
                int'($urandom_range(4, 0)));
    end

    repeat (10) @(posedge clk);
    #1;
    chk("final_q0", q0.size(), 0);
    chk("final_q1", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
